// File: rtl/dds_sweep_ctrl.sv
// Linear frequency-sweep sequencer for the DDS core: steps the tuning word once per dwell interval.
// Optional sweep repetition is compiled in with `define DDS_SWEEP_LOOP_EN.
module dds_sweep_ctrl #(
    parameter int W       = 32,
    parameter int CNT_W   = 16,
    parameter int DWELL_W = 24
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [W-1:0]       cfg_start,
    input  logic [W-1:0]       cfg_step,
    input  logic [CNT_W-1:0]   cfg_count,
    input  logic [DWELL_W-1:0] cfg_dwell,
    input  logic               cfg_loop,
    input  logic               go,
    input  logic               abort,
    output logic [W-1:0]       m,
    output logic               set,
    output logic               en,
    output logic               busy,
    output logic               done
);

    typedef enum logic [1:0] {IDLE, DWELL, DONE} state_t;

    state_t             state;
    logic [W-1:0]       start_q;
    logic [W-1:0]       step_q;
    logic [CNT_W-1:0]   cnt_rld;
    logic [CNT_W-1:0]   remain;
    logic [DWELL_W-1:0] dwell_rld;
    logic [DWELL_W-1:0] dwell_cnt;
    logic               loop_q;
    logic [CNT_W-1:0]   cnt_m1;
    logic [DWELL_W-1:0] dwell_m1;
    logic               expire;

    // A zero count or dwell behaves as one; keep the reload values as N-1 / D-1.
    assign cnt_m1   = (cfg_count == '0) ? '0 : cfg_count - CNT_W'(1);
    assign dwell_m1 = (cfg_dwell == '0) ? '0 : cfg_dwell - DWELL_W'(1);
    assign expire   = (dwell_cnt == '0);

`ifdef DDS_SWEEP_LOOP_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            loop_q <= 1'b0;
        else if (state == IDLE && go && !abort)
            loop_q <= cfg_loop;
    end
`else
    // Loop bit tied off so the restart path folds away.
    logic unused_cfg_loop;
    assign loop_q          = 1'b0;
    assign unused_cfg_loop = cfg_loop;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            start_q   <= '0;
            step_q    <= '0;
            cnt_rld   <= '0;
            remain    <= '0;
            dwell_rld <= '0;
            dwell_cnt <= '0;
            m         <= '0;
            set       <= 1'b0;
            en        <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            set  <= 1'b0;
            done <= 1'b0;
            if (abort) begin
                // m is left alone so the DDS parks on the last word.
                state <= IDLE;
                en    <= 1'b0;
                busy  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (go) begin
                            start_q   <= cfg_start;
                            step_q    <= cfg_step;
                            cnt_rld   <= cnt_m1;
                            remain    <= cnt_m1;
                            dwell_rld <= dwell_m1;
                            dwell_cnt <= dwell_m1;
                            m         <= cfg_start;
                            set       <= 1'b1;
                            en        <= 1'b1;
                            busy      <= 1'b1;
                            state     <= DWELL;
                        end
                    end
                    DWELL: begin
                        if (!expire) begin
                            dwell_cnt <= dwell_cnt - DWELL_W'(1);
                        end else if (remain != '0) begin
                            m         <= m + step_q;
                            set       <= 1'b1;
                            remain    <= remain - CNT_W'(1);
                            dwell_cnt <= dwell_rld;
                        end else if (loop_q) begin
                            m         <= start_q;
                            set       <= 1'b1;
                            remain    <= cnt_rld;
                            dwell_cnt <= dwell_rld;
                        end else begin
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= DONE;
                        end
                    end
                    DONE:    state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Bench for dds_sweep_ctrl: directed vector table, reset/abort sequences and random sweeps
// checked cycle by cycle against a timing-formula model.
module tb_dds_sweep_ctrl;
    localparam int W = 32, CNT_W = 16, DWELL_W = 24;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic [W-1:0]       cfg_start = '0, cfg_step = '0;
    logic [CNT_W-1:0]   cfg_count = '0;
    logic [DWELL_W-1:0] cfg_dwell = '0;
    logic               cfg_loop = 1'b0, go = 1'b0, abort = 1'b0;
    logic [W-1:0]       m;
    logic               set, en, busy, done;

    int n_cmp = 0, n_bad = 0;

    dds_sweep_ctrl #(.W(W), .CNT_W(CNT_W), .DWELL_W(DWELL_W)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start), .cfg_step(cfg_step),
        .cfg_count(cfg_count), .cfg_dwell(cfg_dwell), .cfg_loop(cfg_loop),
        .go(go), .abort(abort), .m(m), .set(set), .en(en), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] start;
        logic [31:0] step;
        int          count;
        int          dwell;
        bit          loop;
        int          abort_at;
        int          ncyc;
        bit          noise;
        int          exp_done;
        logic [31:0] exp_m;
    } vec_t;

    vec_t tbl[6];

    // Sweep under test as seen by the model
    logic [31:0] s_start, s_step;
    int          s_n, s_d, s_abort;
    bit          s_loop;

    // Outputs c cycles after the edge that sampled go, straight from the sweep timing rules.
    function automatic void model(input int c, output logic [31:0] em,
                                  output logic es, output logic een,
                                  output logic ebusy, output logic edone);
        int p, cc, ph;
        p  = s_n * s_d;
        cc = (s_abort > 0 && c > s_abort) ? s_abort : c;
        if (s_loop || cc <= p) begin
            ph    = (cc - 1) % p;
            em    = s_start + s_step * 32'(ph / s_d);
            es    = (ph % s_d == 0);
            een   = 1'b1;
            ebusy = 1'b1;
            edone = 1'b0;
        end else begin
            em    = s_start + s_step * 32'(s_n - 1);
            es    = 1'b0;
            een   = 1'b1;
            ebusy = 1'b0;
            edone = (cc == p + 1);
        end
        if (s_abort > 0 && c > s_abort) begin
            es = 1'b0; een = 1'b0; ebusy = 1'b0; edone = 1'b0;
        end
    endfunction

    task automatic check_out(input string name, input int c, input logic [31:0] em,
                             input logic es, input logic een, input logic ebusy,
                             input logic edone);
        n_cmp++;
        if (m !== em || set !== es || en !== een || busy !== ebusy || done !== edone) begin
            n_bad++;
            $display("FAIL %s c=%0d: got m=%h set=%b en=%b busy=%b done=%b, want m=%h set=%b en=%b busy=%b done=%b",
                     name, c, m, set, en, busy, done, em, es, een, ebusy, edone);
        end
    endtask

    task automatic check_int(input string name, input int got, input int want);
        n_cmp++;
        if (got != want) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    // Entered just after a posedge (+1); leaves the DUT idle at the same phase.
    task automatic run(input vec_t v, input bit use_tbl, input string name);
        logic [31:0] em, last_m;
        logic        es, een, ebusy, edone;
        int          first_done;
        first_done = 0;
        last_m     = '0;
        s_start = v.start;
        s_step  = v.step;
        s_n     = (v.count == 0) ? 1 : v.count;
        s_d     = (v.dwell == 0) ? 1 : v.dwell;
        s_abort = v.abort_at;
`ifdef DDS_SWEEP_LOOP_EN
        s_loop  = v.loop;
`else
        s_loop  = 1'b0;
`endif
        cfg_start = v.start;
        cfg_step  = v.step;
        cfg_count = CNT_W'(v.count);
        cfg_dwell = DWELL_W'(v.dwell);
        cfg_loop  = v.loop;
        go        = 1'b1;
        @(posedge clk); #1;
        for (int c = 1; c <= v.ncyc; c++) begin
            // Scramble config each cycle: only the values captured at go may matter.
            cfg_start = $urandom;
            cfg_step  = $urandom;
            cfg_count = CNT_W'($urandom);
            cfg_dwell = DWELL_W'($urandom);
            cfg_loop  = 1'($urandom);
            abort     = (c == v.abort_at);
            go        = v.noise && (c % 3 == 2) && (c <= s_n * s_d + 1) &&
                        (v.abort_at == 0 || c <= v.abort_at);
            @(negedge clk);
            model(c, em, es, een, ebusy, edone);
            check_out(name, c, em, es, een, ebusy, edone);
            if (done === 1'b1 && first_done == 0) first_done = c;
            last_m = m;
            @(posedge clk); #1;
        end
        go    = 1'b0;
        abort = 1'b0;
        if (use_tbl) begin
            check_int({name, "_done_at"}, first_done, v.exp_done);
            check_int({name, "_last_m"}, int'(last_m), int'(v.exp_m));
        end
    endtask

    initial begin
        vec_t rv;
        int   p;

        tbl[0] = '{32'h0000_1000, 32'h100, 4, 3, 1'b0, 0, 16, 1'b1, 13, 32'h0000_1300};
        tbl[1] = '{32'hFFFF_FF00, 32'h80, 3, 0, 1'b0, 0, 6, 1'b0, 4, 32'h0000_0000};
`ifdef DDS_SWEEP_LOOP_EN
        tbl[2] = '{32'h0000_5000, 32'h10, 2, 2, 1'b1, 12, 14, 1'b1, 0, 32'h0000_5010};
`else
        tbl[2] = '{32'h0000_5000, 32'h10, 2, 2, 1'b1, 12, 14, 1'b1, 5, 32'h0000_5010};
`endif
        tbl[3] = '{32'h0000_2000, 32'h1, 10, 4, 1'b0, 5, 8, 1'b0, 0, 32'h0000_2001};
        tbl[4] = '{32'h0000_ABCD, 32'h7, 0, 0, 1'b0, 0, 4, 1'b0, 2, 32'h0000_ABCD};
        tbl[5] = '{32'h1234_5678, 32'h1111_1111, 1, 5, 1'b0, 0, 8, 1'b0, 6, 32'h1234_5678};

        // Reset state
        #2;
        check_out("reset_state", 0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        check_out("post_release", 0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;

        for (int i = 0; i < 6; i++) run(tbl[i], 1'b1, $sformatf("vec%0d", i));

        // Reset mid-sweep: outputs clear without waiting for an edge, no set after release
        cfg_start = 32'hCAFE_0000; cfg_step = 32'h10; cfg_count = 16'd8; cfg_dwell = 24'd3;
        go = 1'b1;
        @(posedge clk); #1 go = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check_out("async_reset", 0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1 rst_n = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            check_out("after_reset", c, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        @(posedge clk); #1;

        // go and abort together in IDLE: abort wins
        cfg_start = 32'h1; cfg_count = 16'd2; cfg_dwell = 24'd2;
        go = 1'b1; abort = 1'b1;
        @(posedge clk); #1 go = 1'b0; abort = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            check_out("go_abort", c, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        @(posedge clk); #1;

        // Random sweeps
        for (int i = 0; i < 24; i++) begin
            rv.start = $urandom;
            rv.step  = $urandom;
            rv.count = $urandom_range(0, 5);
            rv.dwell = $urandom_range(0, 3);
            rv.loop  = 1'($urandom);
            rv.noise = 1'($urandom);
            p = ((rv.count == 0) ? 1 : rv.count) * ((rv.dwell == 0) ? 1 : rv.dwell);
            rv.abort_at = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, p + 2)) : 0;
`ifdef DDS_SWEEP_LOOP_EN
            if (rv.loop && rv.abort_at == 0) rv.abort_at = $urandom_range(1, 2 * p + 2);
`endif
            rv.ncyc = (rv.abort_at + 2 > p + 3) ? rv.abort_at + 2 : p + 3;
            rv.exp_done = 0;
            rv.exp_m    = '0;
            run(rv, 1'b0, $sformatf("rand%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dds_sweep_ctrl.md
# dds_sweep_ctrl

Sequences the DDS phase accumulator through a linear frequency sweep without host involvement per point. It sits between the UART command decoder and the DDS core. The decoder writes the sweep configuration and issues `go`. This block then drives the DDS tuning word, enable and load strobe, one point every programmable dwell interval.

## Interface

Parameters:
- `W`, 32: tuning-word width.
- `CNT_W`, 16: point-count width.
- `DWELL_W`, 24: dwell-counter width in clock cycles.

Ports:
- `clk` in 1: system clock.
- `rst_n` in 1: reset, asynchronous assert, active-low.
- `cfg_start` in W: first tuning word.
- `cfg_step` in W: increment added per point, unsigned, modulo 2^W.
- `cfg_count` in CNT_W: number of points; 0 is treated as 1.
- `cfg_dwell` in DWELL_W: cycles per point; 0 is treated as 1.
- `cfg_loop` in 1: repeat the sweep indefinitely (see Configuration).
- `go` in 1: single-cycle start request.
- `abort` in 1: single-cycle stop request.
- `m` out W: tuning word to the DDS.
- `set` out 1: single-cycle load strobe; DDS latches `m` while `set`=1.
- `en` out 1: DDS output enable.
- `busy` out 1: a sweep is in progress.
- `done` out 1: single-cycle pulse when a non-looping sweep completes.

## Operation

- Reset values: `m`=0, `set`=0, `en`=0, `busy`=0, `done`=0, state IDLE, internal counters 0.
- States: IDLE, DWELL, DONE.
- IDLE + `go`:
  - Latch all `cfg_*` into shadow registers; later `cfg_*` changes have no effect until the next `go`.
  - `m`<=`cfg_start`, `set`<=1, `en`<=1, `busy`<=1.
  - Points remaining = max(`cfg_count`,1)−1; dwell counter = max(`cfg_dwell`,1)−1.
  - Go to DWELL.
- DWELL:
  - Dwell counter decrements each cycle.
  - On expiry with points remaining >0: `m`<=`m`+step (wrap mod 2^W, no saturation), `set`<=1, decrement remaining, reload dwell, stay in DWELL.
  - On expiry with remaining =0 and loop active: `m`<=start, `set`<=1, reload remaining and dwell.
  - On expiry with remaining =0 and loop inactive: go to DONE.
- DONE: `done`=1 and `busy`=0 for one cycle, then IDLE. `m` and `en` hold, so the DDS keeps the last tone.
- `abort` in any state:
  - Next cycle: IDLE, `en`=0, `busy`=0, `set`=0.
  - `m` holds; no `done` pulse.
- Simultaneous `go` and `abort`: abort wins and `go` is discarded.
- `go` while busy (DWELL or DONE): ignored.
- `go` in IDLE after DONE: starts a new sweep; `en` stays 1.
- Reset mid-sweep: all outputs return to reset values immediately. No `set` pulse is issued on reset release.

## Timing

- `go` sampled high at edge t gives `m`=start and `set`=1 in cycle t+1.
- With D=max(dwell,1) and N=max(count,1), `set` pulses occur at t+1+k·D for k=0..N−1, each lasting exactly one cycle.
- `m` is stable for exactly D cycles per point.
- Non-loop: `done` at t+1+N·D; `busy` high over cycles t+1 … t+N·D.
- Loop: `set` with `m`=start at t+1+N·D; the period is N·D cycles.
- D=1: `set` is high every cycle and `m` changes every cycle.
- `abort` sampled at edge a: `en`=0 in cycle a+1.
- All outputs are registered; no combinational path from inputs to outputs.

## Configuration

- Macro `DDS_SWEEP_LOOP_EN`.
- Defined: `cfg_loop` is latched at `go` and honoured as described.
- Undefined: the port is still present but ignored, and the latched loop bit is constant 0. Every sweep terminates with `done`, and the loop logic is removed from the netlist.

## Test plan

- Reset with `rst_n`=0 mid-sweep → all outputs 0 within the same cycle; no `set` after release.
- start=0x00001000, step=0x100, count=4, dwell=3, `go` → `set` pulses at +1,+4,+7,+10 with `m`=0x1000,0x1100,0x1200,0x1300; `done` at +13; `en` stays 1.
- start=0xFFFFFF00, step=0x80, count=3, dwell=0 → `m`=0xFFFFFF00,0xFFFFFF80,0x00000000 on consecutive cycles; `done` at +4.
- Loop with macro defined: count=2, dwell=2, loop=1 → `m` alternates start, start+step every 2 cycles and no `done` ever. Without the macro the same stimulus gives `done` at +5.
- `abort` on the 5th cycle of a count=10, dwell=4 sweep → `en`=0, `busy`=0 next cycle; `m` holds its last value; no `done`.
- `go` and `abort` together in IDLE → no `set`, `en` stays 0. A second `go` during DWELL → ignored, pulse spacing unchanged.
